// File: rtl/reg_file_sb_if.sv
// Decode/write-back bus of the scoreboarded register file.
// Read ports, two write ports and scoreboard set, grouped for reg_file_sb.
interface reg_file_sb_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              rd_busy_a;
   logic              rd_busy_b;
   logic              wr0_en;
   logic [ADDR_W-1:0] wr0_addr;
   logic [DATA_W-1:0] wr0_data;
   logic              wr1_en;
   logic [ADDR_W-1:0] wr1_addr;
   logic [DATA_W-1:0] wr1_data;
   logic              sb_set;
   logic [ADDR_W-1:0] sb_addr;
   logic              any_busy;

   modport master (
      output rd_addr_a, rd_addr_b, wr0_en, wr0_addr, wr0_data,
             wr1_en, wr1_addr, wr1_data, sb_set, sb_addr,
      input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, any_busy
   );

   modport slave (
      input  rd_addr_a, rd_addr_b, wr0_en, wr0_addr, wr0_data,
             wr1_en, wr1_addr, wr1_data, sb_set, sb_addr,
      output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, any_busy
   );
endinterface

// File: rtl/reg_file_sb.sv
// Two-read/two-write register file with per-register load scoreboard.
// Optional same-cycle write-to-read bypass: define RF_BYPASS_EN.
module reg_file_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 1
) (
   input logic           CLK,
   input logic           RST,
   reg_file_sb_if.slave  bus
);
   localparam int unsigned NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   busy;

   function automatic logic isZero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // wr0 is assigned last so it wins a same-address collision with wr1;
   // likewise sb_set wins over the wr1 busy clear.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         if (bus.wr1_en && !isZero(bus.wr1_addr)) regs[bus.wr1_addr] <= bus.wr1_data;
         if (bus.wr0_en && !isZero(bus.wr0_addr)) regs[bus.wr0_addr] <= bus.wr0_data;
         if (bus.wr1_en) busy[bus.wr1_addr] <= 1'b0;
         if (bus.sb_set && !isZero(bus.sb_addr)) busy[bus.sb_addr] <= 1'b1;
      end
   end

   // Returns {busy, data} as seen by a read port at address a.
   function automatic logic [DATA_W:0] readPort(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] d;
      logic              b;
      d = regs[a];
      b = busy[a];
`ifdef RF_BYPASS_EN
      if (bus.wr1_en && bus.wr1_addr == a) d = bus.wr1_data;
      if (bus.wr0_en && bus.wr0_addr == a) d = bus.wr0_data;
      if (bus.wr1_en && bus.wr1_addr == a && !(bus.sb_set && bus.sb_addr == a)) b = 1'b0;
`endif
      if (isZero(a)) begin
         d = '0;
         b = 1'b0;
      end
      return {b, d};
   endfunction

   always_comb begin
      {bus.rd_busy_a, bus.rd_data_a} = readPort(bus.rd_addr_a);
      {bus.rd_busy_b, bus.rd_data_b} = readPort(bus.rd_addr_b);
      bus.any_busy = |busy;
   end
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed table, corner sequences,
// and randomized traffic against an array-based reference model.
module tb_reg_file_sb;
   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   nCmp = 0;
   int   nBad = 0;

   reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        w0; logic [4:0] a0; logic [31:0] d0;
      logic        w1; logic [4:0] a1; logic [31:0] d1;
      logic        sb; logic [4:0] sa;
      logic [4:0]  ra; logic [31:0] ed; logic eb; logic eany;
   } vec_t;

   vec_t tbl [11];

   logic [31:0] mReg  [32];
   logic        mBusy [32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      bus.wr0_en = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
      bus.wr1_en = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
      bus.sb_set = 1'b0; bus.sb_addr  = '0;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 32; i++) begin
         mReg[i]  = '0;
         mBusy[i] = 1'b0;
      end
   endtask

   // Architectural effect of one clock edge, from the documented rules.
   task automatic modelEdge();
      if (bus.wr0_en && bus.wr0_addr != 0)
         mReg[bus.wr0_addr] = bus.wr0_data;
      if (bus.wr1_en && bus.wr1_addr != 0 && !(bus.wr0_en && bus.wr0_addr == bus.wr1_addr))
         mReg[bus.wr1_addr] = bus.wr1_data;
      if (bus.sb_set && bus.sb_addr != 0)
         mBusy[bus.sb_addr] = 1'b1;
      if (bus.wr1_en && !(bus.sb_set && bus.sb_addr == bus.wr1_addr))
         mBusy[bus.wr1_addr] = 1'b0;
   endtask

   function automatic logic [31:0] expData(input logic [4:0] a);
      if (a == 0) return '0;
`ifdef RF_BYPASS_EN
      if (bus.wr0_en && bus.wr0_addr == a) return bus.wr0_data;
      if (bus.wr1_en && bus.wr1_addr == a) return bus.wr1_data;
`endif
      return mReg[a];
   endfunction

   function automatic logic expBusy(input logic [4:0] a);
      if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
      if (bus.wr1_en && bus.wr1_addr == a && !(bus.sb_set && bus.sb_addr == a)) return 1'b0;
`endif
      return mBusy[a];
   endfunction

   function automatic logic expAny();
      for (int i = 0; i < 32; i++) if (mBusy[i]) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      logic [31:0] sameExp;
      logic        busyExp;

      idle();
      bus.rd_addr_a = '0;
      bus.rd_addr_b = '0;
      repeat (2) @(posedge CLK);
      #1;
      check("reset_any_busy_low", {31'b0, bus.any_busy}, 32'd0);
      @(negedge CLK) RST = 1'b1;
      @(posedge CLK) #1;

      for (int i = 0; i < 32; i++) begin
         bus.rd_addr_a = 5'(i);
         bus.rd_addr_b = 5'(31 - i);
         #1;
         check("reset_data_a", bus.rd_data_a, 32'd0);
         check("reset_data_b", bus.rd_data_b, 32'd0);
         check("reset_busy_a", {31'b0, bus.rd_busy_a}, 32'd0);
      end
      check("reset_any_busy", {31'b0, bus.any_busy}, 32'd0);

      tbl[0]  = '{1, 5, 32'h1234_5678, 0, 0, 0,           0, 0, 5, 32'h1234_5678, 0, 0};
      tbl[1]  = '{1, 7, 32'hAAAA_AAAA, 1, 7, 32'h5555_5555, 0, 0, 7, 32'hAAAA_AAAA, 0, 0};
      tbl[2]  = '{1, 0, 32'hFFFF_FFFF, 0, 0, 0,           0, 0, 0, 32'h0,         0, 0};
      tbl[3]  = '{0, 0, 0,             0, 0, 0,           1, 9, 9, 32'h0,         1, 1};
      tbl[4]  = '{0, 0, 0,             1, 9, 32'h42,      0, 0, 9, 32'h42,        0, 0};
      tbl[5]  = '{0, 0, 0,             1, 9, 32'h99,      1, 9, 9, 32'h99,        1, 1};
      tbl[6]  = '{0, 0, 0,             1, 9, 32'h77,      0, 0, 9, 32'h77,        0, 0};
      tbl[7]  = '{0, 0, 0,             0, 0, 0,           1, 0, 0, 32'h0,         0, 0};
      tbl[8]  = '{0, 0, 0,             1, 4, 32'h44,      1, 3, 3, 32'h0,         1, 1};
      tbl[9]  = '{0, 0, 0,             1, 3, 32'h33,      1, 4, 4, 32'h44,        1, 1};
      tbl[10] = '{0, 0, 0,             1, 4, 32'h45,      0, 0, 4, 32'h45,        0, 0};

      // First entry writes reg 5; a same-cycle read shows old value unless bypassed.
      for (int i = 0; i < 11; i++) begin
         bus.wr0_en = tbl[i].w0; bus.wr0_addr = tbl[i].a0; bus.wr0_data = tbl[i].d0;
         bus.wr1_en = tbl[i].w1; bus.wr1_addr = tbl[i].a1; bus.wr1_data = tbl[i].d1;
         bus.sb_set = tbl[i].sb; bus.sb_addr  = tbl[i].sa;
         bus.rd_addr_a = tbl[i].ra;
         #1;
         if (i == 0) begin
`ifdef RF_BYPASS_EN
            sameExp = 32'h1234_5678;
`else
            sameExp = 32'h0;
`endif
            check("same_cycle_read", bus.rd_data_a, sameExp);
         end
         @(posedge CLK) #1;
         idle();
         #1;
         check("tbl_data", bus.rd_data_a, tbl[i].ed);
         check("tbl_busy", {31'b0, bus.rd_busy_a}, {31'b0, tbl[i].eb});
         check("tbl_any_busy", {31'b0, bus.any_busy}, {31'b0, tbl[i].eany});
      end

      // Busy bypass: load return on reg 12 seen in the returning cycle.
      bus.sb_set = 1'b1; bus.sb_addr = 5'd12;
      @(posedge CLK) #1;
      idle();
      bus.wr1_en = 1'b1; bus.wr1_addr = 5'd12; bus.wr1_data = 32'hBEEF;
      bus.rd_addr_b = 5'd12;
      #1;
`ifdef RF_BYPASS_EN
      busyExp = 1'b0; sameExp = 32'hBEEF;
`else
      busyExp = 1'b1; sameExp = 32'h0;
`endif
      check("same_cycle_busy_b", {31'b0, bus.rd_busy_b}, {31'b0, busyExp});
      check("same_cycle_data_b", bus.rd_data_b, sameExp);
      @(posedge CLK) #1;
      idle();
      #1;
      check("ret_busy_b", {31'b0, bus.rd_busy_b}, 32'd0);
      check("ret_data_b", bus.rd_data_b, 32'hBEEF);

      // Asynchronous reset in the middle of a pending write.
      bus.wr0_en = 1'b1; bus.wr0_addr = 5'd3; bus.wr0_data = 32'h10;
      @(posedge CLK) #1;
      idle();
      bus.rd_addr_a = 5'd3;
      #1;
      check("pre_reset_reg3", bus.rd_data_a, 32'h10);
      bus.wr0_en = 1'b1; bus.wr0_addr = 5'd3; bus.wr0_data = 32'h55;
      bus.sb_set = 1'b1; bus.sb_addr = 5'd11;
      #2 RST = 1'b0;
      #1;
      check("async_reset_reg3", bus.rd_data_a, 32'h0);
      check("async_reset_any_busy", {31'b0, bus.any_busy}, 32'd0);
      @(posedge CLK) #1;
      check("held_reset_reg3", bus.rd_data_a, 32'h0);
      check("held_reset_any_busy", {31'b0, bus.any_busy}, 32'd0);
      idle();
      @(negedge CLK) RST = 1'b1;
      @(posedge CLK) #1;
      bus.rd_addr_b = 5'd11;
      #1;
      check("post_reset_reg3", bus.rd_data_a, 32'h0);
      check("post_reset_busy11", {31'b0, bus.rd_busy_b}, 32'd0);

      // Randomized traffic against the reference model, from a clean reset.
      RST = 1'b0;
      modelReset();
      @(negedge CLK) RST = 1'b1;
      @(posedge CLK) #1;
      for (int n = 0; n < 600; n++) begin
         bus.wr0_en   = 1'($urandom_range(0, 1));
         bus.wr0_addr = 5'($urandom_range(0, 7));
         bus.wr0_data = $urandom;
         bus.wr1_en   = 1'($urandom_range(0, 1));
         bus.wr1_addr = 5'($urandom_range(0, 7));
         bus.wr1_data = $urandom;
         bus.sb_set   = 1'($urandom_range(0, 2) == 0);
         bus.sb_addr  = 5'($urandom_range(0, 7));
         bus.rd_addr_a = 5'($urandom_range(0, 7));
         bus.rd_addr_b = (n % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         #2;
         check("rand_data_a", bus.rd_data_a, expData(bus.rd_addr_a));
         check("rand_data_b", bus.rd_data_b, expData(bus.rd_addr_b));
         check("rand_busy_a", {31'b0, bus.rd_busy_a}, {31'b0, expBusy(bus.rd_addr_a)});
         check("rand_busy_b", {31'b0, bus.rd_busy_b}, {31'b0, expBusy(bus.rd_addr_b)});
         check("rand_any_busy", {31'b0, bus.any_busy}, {31'b0, expAny()});
         @(posedge CLK);
         modelEdge();
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single-cycle CPU register file.
- Two combinational read ports and two synchronous write ports:
  - port 0: ALU/early write-back.
  - port 1: late data-memory load return.
- Per-register scoreboard (busy bit) lets a multi-cycle datapath detect RAW hazards on outstanding loads.
- Sits between decode (reads) and write-back (writes) in the multi-cycle CPU.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 5, register address width; number of registers NREG = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes; when 0 register 0 is ordinary.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- rd_addr_a  in  ADDR_W  read port A address (rs).
- rd_addr_b  in  ADDR_W  read port B address (rt).
- rd_data_a  out  DATA_W  read port A data.
- rd_data_b  out  DATA_W  read port B data.
- rd_busy_a  out  1  scoreboard bit of rd_addr_a.
- rd_busy_b  out  1  scoreboard bit of rd_addr_b.
- wr0_en  in  1  write port 0 enable.
- wr0_addr  in  ADDR_W  write port 0 address.
- wr0_data  in  DATA_W  write port 0 data.
- wr1_en  in  1  write port 1 (load return) enable; also clears busy bit of wr1_addr.
- wr1_addr  in  ADDR_W  write port 1 address.
- wr1_data  in  DATA_W  write port 1 data.
- sb_set  in  1  mark sb_addr busy (load issued).
- sb_addr  in  ADDR_W  scoreboard set address.
- any_busy  out  1  OR of all busy bits (drain/flush indicator).

Behaviour:
- Reset (RST=0, asynchronous, any time including mid-write):
  - all NREG registers cleared to 0.
  - all busy bits cleared.
  - outputs then read 0 / not busy.
  - Release is synchronous to next rising edge; no write is taken on the edge RST is sampled low.
- Reads: purely combinational from array, zero-cycle latency.
  - If ZERO_REG=1 and address==0: data=0, busy=0 regardless of array state.
- Writes: on rising CLK, each enabled port writes its data to its address.
- Write collision (wr0_en & wr1_en & wr0_addr==wr1_addr): wr0 data is stored.
  - wr0 is the younger instruction in program order; its result must win.
  - The busy bit is still cleared by wr1.
- ZERO_REG=1: writes to address 0 from either port are dropped; sb_set to address 0 is ignored.
- Scoreboard, per-register bit, rising edge:
  - sb_set sets busy[sb_addr].
  - wr1_en clears busy[wr1_addr].
  - Same address on both in one cycle: set wins (new load issued on same cycle old one returns); result busy=1.
  - Different addresses: both take effect.
  - wr0 does not affect busy bits.
  - sb_set on an already-busy register keeps it busy (no counting).
- any_busy: combinational OR over busy array; 0 after reset.
- No internal FSM beyond register/scoreboard state; no backpressure; caller guarantees one outstanding load per register.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined:
  - rd_data_x returns the same-cycle write data when an enabled write port targets rd_addr_x (wr0 priority over wr1).
  - rd_busy_x reads 0 when wr1_en targets rd_addr_x and sb_set does not target it in that cycle.
  - Zero-register rule still applies.
- Undefined: reads return array contents only; a written value becomes visible the cycle after the write edge.

Test Plan:
- Reset then read all 32 addresses -> every rd_data=0, rd_busy=0, any_busy=0.
- wr0 addr 5 data 0x1234_5678, next cycle read A=5 -> 0x1234_5678. Same-cycle read: without RF_BYPASS_EN -> 0; with RF_BYPASS_EN -> 0x1234_5678.
- wr0 and wr1 both to addr 7 (0xAAAA_AAAA / 0x5555_5555) -> reg7=0xAAAA_AAAA.
- wr0 to addr 0 data 0xFFFF_FFFF, read addr 0 -> 0.
- sb_set addr 9 -> rd_busy=1 and any_busy=1 next cycle.
  - wr1 addr 9 data 0x42 -> busy=0, data=0x42 next cycle.
  - sb_set and wr1 both addr 9 same edge -> busy stays 1, data=wr1_data.
- RST pulsed low mid-cycle with wr0_en=1 to addr 3 and reg 3=0x10 -> reg3=0 immediately and after release; busy bits all 0.
